// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO serial receiver.
// Holds the FSM state encoding and the bit-counter width calculation.
// No logic; imported by the receiver top and its holding buffer.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Single-entry valid/ready holding register for completed words.
// Latency: a word is visible on dout the cycle after word_done.
// Backpressure: a word arriving while full and not being accepted is dropped and flagged.
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun_evt
);

  // Full, nobody taking the old word, and a new one arrives: the new one is lost.
  assign overrun_evt = word_done && dout_valid && !dout_ready;

  // Load on completion when the slot is free or freed this edge; otherwise drain on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (word_done && (!dout_valid || dout_ready)) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (!word_done && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out receiver: frames qualified bits into WIDTH-bit words.
// Latency: word appears on dout one cycle after the edge sampling its last bit.
// Backpressure: single holding slot; words completing into a full, unaccepted slot set overrun.
module shift_reg_sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (WIDTH < 2) begin : g_width_check
    $error("shift_reg_sipo_rx: WIDTH must be at least 2");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_first;
  logic             word_done;
  logic             resync_evt;
  logic             overrun_evt;

  // sr_first places a start bit so that WIDTH-1 further shifts land it at the word's first-bit position.
  if (MSB_FIRST) begin : g_msb
    assign sr_shift = {sr[WIDTH-2:0], sdi};
    assign sr_first = {{(WIDTH-1){1'b0}}, sdi};
  end else begin : g_lsb
    assign sr_shift = {sdi, sr[WIDTH-1:1]};
    assign sr_first = {sdi, {(WIDTH-1){1'b0}}};
  end

  // State, counter and shift register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // Next-state logic: start, collect, resync on early frame_start, complete at bit WIDTH.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sr_nxt     = sr;
    word_done  = 1'b0;
    resync_evt = 1'b0;
    case (state)
      IDLE: begin
        if (sdi_valid && frame_start) begin
          sr_nxt    = sr_first;
          cnt_nxt   = ONE;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sdi_valid) begin
          if (frame_start) begin
            sr_nxt     = sr_first;
            cnt_nxt    = ONE;
            resync_evt = 1'b1;
          end else begin
            sr_nxt = sr_shift;
            if (cnt == LAST) begin
              word_done = 1'b1;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = cnt + ONE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .word        (sr_shift),
    .word_done   (word_done),
    .dout_ready  (dout_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overrun_evt (overrun_evt)
  );

  // Sticky status flags; a set event on the same edge as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (resync_evt)   frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (overrun_evt)  overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Bench for shift_reg_sipo_rx: MSB-first and LSB-first instances share one stimulus.
// Reference model collects bits in a queue and forms words arithmetically.
// Directed steps first, then a randomized stream.
module tb_shift_reg_sipo_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, sdi, sdi_valid, frame_start, dout_ready, err_clr;
  logic [W-1:0] dout_m, dout_l;
  logic dv_m, dv_l, fe_m, fe_l, ov_m, ov_l;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  bit           q[$];
  bit           in_word;
  bit           hv, fe, ov;
  logic [W-1:0] hm, hl;

  always #5 clk = ~clk;

  shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid),
    .frame_start(frame_start), .dout(dout_m), .dout_valid(dv_m),
    .dout_ready(dout_ready), .frame_err(fe_m), .overrun(ov_m), .err_clr(err_clr));

  shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid),
    .frame_start(frame_start), .dout(dout_l), .dout_valid(dv_l),
    .dout_ready(dout_ready), .frame_err(fe_l), .overrun(ov_l), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply the spec rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit done, fset;
    logic [W-1:0] wm, wl;
    done = 0; fset = 0; wm = '0; wl = '0;
    if (reset) begin
      q.delete(); in_word = 0;
      hv = 0; hm = '0; hl = '0; fe = 0; ov = 0;
      return;
    end
    if (sdi_valid) begin
      if (frame_start) begin
        if (in_word) fset = 1;
        q.delete(); q.push_back(sdi); in_word = 1;
      end else if (in_word) begin
        q.push_back(sdi);
        if (q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm = wm + (W'(q[i]) << (W - 1 - i));
            wl = wl + (W'(q[i]) << i);
          end
          done = 1; q.delete(); in_word = 0;
        end
      end
    end
    if (done && hv && !dout_ready) begin
      ov = 1;
    end else begin
      if (err_clr) ov = 0;
    end
    if (fset) fe = 1;
    else if (err_clr) fe = 0;
    if (done && (!hv || dout_ready)) begin
      hv = 1; hm = wm; hl = wl;
    end else if (!done && dout_ready) begin
      hv = 0;
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic f, input logic r,
                     input logic c, input logic rst);
    reset = rst; sdi = s; sdi_valid = v; frame_start = f; dout_ready = r; err_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    chk("dout_msb",  dout_m, hm);
    chk("dout_lsb",  dout_l, hl);
    chk("valid_msb", W'(dv_m), W'(hv));
    chk("valid_lsb", W'(dv_l), W'(hv));
    chk("ferr_msb",  W'(fe_m), W'(fe));
    chk("ferr_lsb",  W'(fe_l), W'(fe));
    chk("ovr_msb",   W'(ov_m), W'(ov));
    chk("ovr_lsb",   W'(ov_l), W'(ov));
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'($urandom), 1'b0, 1'($urandom), r, 1'b0, 1'b0);
  endtask

  // Send one framed word first bit = w[W-1]; rdy_last applies on the completing edge.
  task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input logic rdy_other);
    for (int i = 0; i < W; i++)
      cyc(w[W-1-i], 1'b1, (i == 0), (i == W-1) ? rdy_last : rdy_other, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1; sdi = 0; sdi_valid = 0; frame_start = 0; dout_ready = 0; err_clr = 0;
    in_word = 0; hv = 0; fe = 0; ov = 0; hm = '0; hl = '0;

    // reset state
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // basic word 1010, held under backpressure, then accepted
    send_word(4'b1010, 0, 0);
    idle(3, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(1, 0);

    // PISO-style loopback of 0101 (LSB-first instance gives 1010)
    send_word(4'b0101, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // stray bits in IDLE are ignored
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // 1,1,0,1 with gaps of 0, 3, 7
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(3, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(7, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // resync mid-word, then clear the flag
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    send_word(4'b0011, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    idle(1, 0);

    // resync coinciding with err_clr: set wins
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // back-to-back with no accept: overrun, first word kept
    send_word(4'hA, 0, 0);
    send_word(4'h5, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    idle(1, 0);
    // accept coinciding with second completion: replaced, no overrun
    send_word(4'hA, 0, 0);
    send_word(4'h5, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // reset mid-word, and reset while holding a word
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    send_word(4'h9, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    send_word(4'h6, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // randomized stream
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 5) == 0),
          1'($urandom),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/shift_reg_sipo_rx.md
Name: shift_reg_sipo_rx

Overview:
Serial-in/parallel-out receiver that pairs with the PISO shifter at the far end of the same serial link. It samples qualified serial bits, MSB first, and assembles them into WIDTH-bit words. Completed words go into an output holding register with a valid/ready handshake. Framing errors and overruns are reported as sticky status flags.

Parameters:
WIDTH, 4, word width in bits; must be 2 or more.
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1] (matches the PISO, which shifts out piso[3] first); 0 = first bit lands in dout[0].

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset. One clock, no async paths.
sdi  input  1  serial data bit.
sdi_valid  input  1  qualifies sdi in this cycle; bits are ignored when low.
frame_start  input  1  marks the qualified bit as the first bit of a word; only meaningful when sdi_valid=1.
dout  output  WIDTH  assembled parallel word.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  consumer accepts dout on a cycle where dout_valid=1 and dout_ready=1.
frame_err  output  1  sticky; frame_start seen before the current word completed.
overrun  output  1  sticky; a word completed while the holding register was still full.
err_clr  input  1  clears frame_err and overrun.

Behaviour:
- Reset (reset=1 at a rising clk) forces:
  - state=IDLE, shift register=0, bit count=0
  - dout=0, dout_valid=0, frame_err=0, overrun=0
- Reset mid-word discards the partial word and discards any held dout.
- States:
  - IDLE: waiting for a word start.
  - SHIFT: collecting bits.
- IDLE behaviour:
  - sdi_valid=1 and frame_start=1: capture sdi as bit 1, count=1, go to SHIFT.
  - sdi_valid=1 and frame_start=0: bit dropped, stay in IDLE, no flag raised.
- SHIFT behaviour:
  - sdi_valid=1 and frame_start=0: shift sdi in, count+1.
    - MSB_FIRST=1 shifts as sr <= {sr[WIDTH-2:0], sdi}.
    - MSB_FIRST=0 shifts as sr <= {sdi, sr[WIDTH-1:1]}.
  - sdi_valid=1 and frame_start=1: resync. Discard the partial word, capture sdi as bit 1, count=1, set frame_err, stay in SHIFT.
  - sdi_valid=0: hold everything; gaps of any length between bits are legal.
- Word completion: the edge that samples bit WIDTH completes the word; the FSM returns to IDLE and count=0.
- Completion when WIDTH=1 is not supported; the parameter check requires WIDTH >= 2.
- Latency: the completed word is on dout with dout_valid=1 in the cycle right after the edge that sampled its last bit.
- Back-to-back words need no idle cycle: a frame_start bit in the cycle after completion is accepted from IDLE.
- Handshake:
  - dout_valid stays high and dout stays stable until a cycle with dout_ready=1.
  - On that cycle's edge dout_valid clears, unless a new word completes on the same edge.
- Holding-register boundary cases, for a word completing on an edge:
  - dout_valid=0: load dout, set dout_valid.
  - dout_valid=1 and dout_ready=1 (simultaneous accept and completion): load the new word, dout_valid stays 1, no overrun.
  - dout_valid=1 and dout_ready=0: keep the old dout, drop the new word, set overrun.
- dout_ready while dout_valid=0 has no effect.
- Sticky flags:
  - err_clr=1 clears both flags on the next edge.
  - If a set event coincides with err_clr, set wins.
- Bit counter is $clog2(WIDTH+1) bits wide and never wraps past WIDTH.

Decomposition:
- Package sipo_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - a function computing the counter width from WIDTH.
- One natural sub-module, sipo_out_buf: the single-entry valid/ready holding register with overrun detection.
  - Inputs: word, word_done, dout_ready.
  - Outputs: dout, dout_valid, overrun_evt.
- The shift register, counter and FSM stay in the top module.

Test Plan:
1. Reset, then send frame_start+1,0,1,0 on 4 consecutive sdi_valid cycles with dout_ready=0 -> one cycle after the 4th bit, dout=4'b1010 and dout_valid=1, held until dout_ready=1; no flags.
2. Loopback from a PISO loaded with d=4'b0101, pl pulsed, first shifted bit tagged frame_start -> dout=4'b0101. With MSB_FIRST=0 the same stream gives 4'b1010.
3. Stream 1,1,0,1 with sdi_valid=0 gaps of 0, 3 and 7 cycles between bits -> dout=4'b1101; bit count holds during gaps.
4. After bits 1,1, assert frame_start with bits 0,0,1,1 -> frame_err=1 and dout=4'b0011. Pulse err_clr -> frame_err=0 next cycle.
5. Two back-to-back words 4'hA then 4'h5, with dout_ready=0 throughout -> dout=4'hA, overrun=1. Repeat with dout_ready=1 on the completion edge of the second word -> dout=4'h5, overrun=0.
6. Assert reset after 2 bits and again while dout_valid=1 -> next cycle state=IDLE, dout=0, dout_valid=0, flags=0; the next full frame decodes correctly.
